get_resp_parser: RTL and testbench

Receive-side counterpart to the UART request sequencer: once a `get.lua` request line has gone out, this block consumes bytes from the UART receiver and scans each response line for the arm-state token. It reports `ARM` or `DISARM`, or a timeout if no match arrives in time. It sits between the UART RX byte interface and the security-system controller, which pulses `start` immediately after the request sequencer's `done`.

---
 rtl/get_resp_parser_if.sv | 16 +
 rtl/get_resp_parser.sv | 136 +++++++++++++
 tb/tb_get_resp_parser.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/get_resp_parser_if.sv
// Handshake/bus bundle between the UART RX byte stream, the controller and get_resp_parser.
// master = controller/UART side, slave = the parser.
interface get_resp_parser_if;
    logic       start;
    logic [7:0] rxdata;
    logic       rxvalid;
    logic       busy;
    logic       done;
    logic [1:0] result;

    // rxvalid is a one-cycle strobe per byte with no back-pressure: the parser accepts every
    // strobe it sees in SCAN and drops strobes in any other state. done is a one-cycle pulse,
    // and result holds its value until the next accepted start.
    modport master (output start, rxdata, rxvalid, input busy, done, result);
    modport slave  (input start, rxdata, rxvalid, output busy, done, result);
endinterface

// File: rtl/get_resp_parser.sv
// Scans UART response lines for the exact tokens "ARM" / "DISARM" and reports a match or a timeout.
// Optional macro RESP_CASE_FOLD_EN folds lowercase letters to uppercase before the token compare.
module get_resp_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    get_resp_parser_if.slave   bus,
    output logic [1:0]         dbg_state
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    result_q, result_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [2:0]    len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          arm_ok_q, arm_ok_d;
    logic          dis_ok_q, dis_ok_d;
    logic [7:0]    byte_c;
    logic          nl_c;

    function automatic logic [7:0] arm_chr(input logic [2:0] i);
        case (i)
            3'd0:    arm_chr = 8'h41;
            3'd1:    arm_chr = 8'h52;
            default: arm_chr = 8'h4D;
        endcase
    endfunction

    function automatic logic [7:0] dis_chr(input logic [2:0] i);
        case (i)
            3'd0:    dis_chr = 8'h44;
            3'd1:    dis_chr = 8'h49;
            3'd2:    dis_chr = 8'h53;
            3'd3:    dis_chr = 8'h41;
            3'd4:    dis_chr = 8'h52;
            default: dis_chr = 8'h4D;
        endcase
    endfunction

    always_comb begin
`ifdef RESP_CASE_FOLD_EN
        if (bus.rxdata >= 8'h61 && bus.rxdata <= 8'h7A) byte_c = bus.rxdata - 8'h20;
        else                                            byte_c = bus.rxdata;
`else
        byte_c = bus.rxdata;
`endif
        nl_c = bus.rxvalid && (bus.rxdata == 8'h0A);
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        arm_ok_d = arm_ok_q;
        dis_ok_d = dis_ok_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_SCAN;
                    result_d = 2'b00;
                    len_d    = 3'd0;
                    cnt_d    = '0;
                    arm_ok_d = 1'b1;
                    dis_ok_d = 1'b1;
                end
            end
            S_SCAN: begin
                cnt_d = cnt_q + CW'(1);
                // A completed match outranks a timeout landing on the same edge.
                if (nl_c && arm_ok_q && len_q == 3'd3) begin
                    result_d = 2'b01;
                    state_d  = S_FINISH;
                end else if (nl_c && dis_ok_q && len_q == 3'd6) begin
                    result_d = 2'b10;
                    state_d  = S_FINISH;
                end else if (cnt_q == CNT_LAST) begin
                    result_d = 2'b11;
                    state_d  = S_FINISH;
                end else if (nl_c) begin
                    len_d    = 3'd0;
                    arm_ok_d = 1'b1;
                    dis_ok_d = 1'b1;
                end else if (bus.rxvalid && bus.rxdata != 8'h0D) begin
                    arm_ok_d = arm_ok_q && (len_q < 3'd3) && (byte_c == arm_chr(len_q));
                    dis_ok_d = dis_ok_q && (len_q < 3'd6) && (byte_c == dis_chr(len_q));
                    // Saturate so an overlong line can never look like length 3 or 6.
                    if (len_q != 3'd7) len_d = len_q + 3'd1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_SCAN);
        done_d = (state_d == S_FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= 2'b00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            len_q    <= 3'd0;
            cnt_q    <= '0;
            arm_ok_q <= 1'b1;
            dis_ok_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            arm_ok_q <= arm_ok_d;
            dis_ok_q <= dis_ok_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_get_resp_parser.sv
// Directed bench for get_resp_parser: token matching, near misses, timeout, collision, reset and restart.
module tb_get_resp_parser;
    localparam int T = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         tests = 0;
    int         fails = 0;
    logic [1:0] exp_q[$];

    get_resp_parser_if bus();

    get_resp_parser #(.TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_done: observed result %0h expected no done", bus.result);
            end
            if (exp_q.size() != 0) check("sb_result", 32'(bus.result), 32'(exp_q.pop_front()));
        end
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rxvalid = 1'b1;
        bus.rxdata  = b;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic do_start;
        @(negedge clk);
        bus.rxvalid = 1'b0;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("result_cleared", 32'(bus.result), 32'd0);
    endtask

    task automatic finish_check(input string tag, input logic [1:0] r);
        exp_q.push_back(r);
        @(negedge clk);
        bus.rxvalid = 1'b0;
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_result"}, 32'(bus.result), 32'(r));
        @(negedge clk);
        check({tag, "_done_1cyc"}, 32'(bus.done), 32'd0);
        check({tag, "_idle"}, 32'(dbg_state), 32'd0);
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while (bus.done !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.rxvalid = 1'b0;
        bus.rxdata  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;

        // echo line discarded, then ARM
        do_start;
        send_str("dofile(\"get.lua\")\r\n");
        send_str("ARM\r\n");
        finish_check("happy", 2'b01);
        check("happy_held", 32'(bus.result), 32'd1);

        // bytes outside SCAN are dropped and result stays held
        send_str("DISARM\n");
        @(negedge clk);
        bus.rxvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_rx_held", 32'(bus.result), 32'd1);
        check("idle_rx_state", 32'(dbg_state), 32'd0);

        do_start;
        send_str("DISARM\n");
        finish_check("disarm", 2'b10);

        do_start;
        send_str("ARMED\r\n");
        send_str("AR\n");
        send_str("DISARM\r\n");
        finish_check("near_miss", 2'b10);

        // start mid-line must not reset the line state
        do_start;
        send_str("DIS");
        @(negedge clk);
        bus.rxvalid = 1'b0;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        send_str("ARM\n");
        finish_check("start_in_scan", 2'b10);

        // timeout exactly T cycles after SCAN entry
        do_start;
        repeat (T - 1) @(negedge clk);
        check("to_early_done", 32'(bus.done), 32'd0);
        check("to_early_busy", 32'(bus.busy), 32'd1);
        exp_q.push_back(2'b11);
        @(negedge clk);
        check("to_done", 32'(bus.done), 32'd1);
        check("to_result", 32'(bus.result), 32'd3);
        check("to_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);

        // final newline of ARM lands on the timeout edge
        do_start;
        repeat (T - 5) @(negedge clk);
        send_str("ARM\n");
        finish_check("collision", 2'b01);

        // reset mid-line
        do_start;
        send_str("DISA");
        @(negedge clk);
        bus.rxvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_result", 32'(bus.result), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_start;
        send_str("ARM\n");
        finish_check("after_rst", 2'b01);

        // lowercase token
        do_start;
        send_str("arm\r\n");
`ifdef RESP_CASE_FOLD_EN
        finish_check("fold", 2'b01);
`else
        @(negedge clk);
        bus.rxvalid = 1'b0;
        exp_q.push_back(2'b11);
        wait_done("nofold", T + 5);
        check("nofold_result", 32'(bus.result), 32'd3);
        @(negedge clk);
`endif

        // start held high through FINISH re-arms the next parse
        @(negedge clk);
        bus.start = 1'b1;
        send_str("ARM\n");
        exp_q.push_back(2'b01);
        @(negedge clk);
        bus.rxvalid = 1'b0;
        check("held_done", 32'(bus.done), 32'd1);
        check("held_result", 32'(bus.result), 32'd1);
        @(negedge clk);
        check("held_idle", 32'(dbg_state), 32'd0);
        @(negedge clk);
        check("held_rearm_busy", 32'(bus.busy), 32'd1);
        check("held_rearm_result", 32'(bus.result), 32'd0);
        bus.start = 1'b0;
        exp_q.push_back(2'b11);
        wait_done("held_timeout", T + 5);
        check("held_timeout_result", 32'(bus.result), 32'd3);

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
